// File: rtl/atetris_inp_cond_if.sv
// Control-panel bus between the raw cabinet inputs and the game core.
// Carries raw controls in, conditioned controls and coin count out.
interface atetris_inp_cond_if;
  logic [10:0] IRAW;
  logic [10:0] INP;
  logic [7:0]  COINCNT;

  modport master (
    output IRAW,
    input  INP,
    input  COINCNT
  );

  modport slave (
    input  IRAW,
    output INP,
    output COINCNT
  );
endinterface

// File: rtl/atetris_inp_cond.sv
// Input conditioner: sync, tick-based debounce, coin pulse shaping.
// Coin pulse FSMs are built only when ATETRIS_COIN_PULSE_EN is defined.
module atetris_inp_cond #(
  parameter int TICK_DIV = 14318,
  parameter int DB_CNT   = 4,
  parameter int COIN_LEN = 50
) (
  input logic MCLK,
  input logic RESET_N,
  atetris_inp_cond_if.slave io
);
  localparam logic [15:0] TD_M1 = 16'(TICK_DIV - 1);
  localparam logic [3:0]  DB_M1 = 4'(DB_CNT - 1);
  localparam logic [7:0]  CL    = 8'(COIN_LEN);

  logic [10:0]      sync1;
  logic [10:0]      sync2;
  logic [10:0]      stable;
  logic [10:0][3:0] dcnt;
  logic [15:0]      pre;
  logic             tick;
  logic [1:0]       rise;
  logic [1:0]       coin_inp;
  logic [1:0]       counted;
  logic [7:0]       coincnt;
  logic [10:0]      inp;

  always_ff @(posedge MCLK) begin
    if (!RESET_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= io.IRAW;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge MCLK) begin
    if (!RESET_N)  pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 16'd1;
  end

  assign tick = (pre == TD_M1);

  always_ff @(posedge MCLK) begin
    if (!RESET_N) begin
      stable <= '0;
      dcnt   <= '0;
    end else if (tick) begin
      for (int i = 0; i < 11; i++) begin
        if (sync2[i] == stable[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DB_M1) begin
          stable[i] <= sync2[i];
          dcnt[i]   <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 4'd1;
        end
      end
    end
  end

  // coin level being accepted high on this edge
  always_comb begin
    rise = '0;
    for (int c = 0; c < 2; c++)
      rise[c] = tick & sync2[8+c] & ~stable[8+c]
              & (dcnt[8+c] == DB_M1);
  end

`ifdef ATETRIS_COIN_PULSE_EN
  typedef enum logic [1:0] {
    IDLE, PULSE, WAITREL
  } coin_st_t;

  coin_st_t        st    [2];
  coin_st_t        st_nx [2];
  logic [1:0][7:0] pcnt;
  logic [1:0]      take;
  logic [1:0]      pulse;

  always_ff @(posedge MCLK) begin
    if (!RESET_N) begin
      for (int c = 0; c < 2; c++) st[c] <= IDLE;
      pcnt <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        st[c] <= st_nx[c];
        if (take[c])
          pcnt[c] <= CL;
        else if (st[c] == PULSE && tick)
          pcnt[c] <= pcnt[c] - 8'd1;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      st_nx[c] = st[c];
      take[c]  = 1'b0;
      unique case (st[c])
        IDLE: begin
          if (rise[c]) begin
            st_nx[c] = PULSE;
            take[c]  = 1'b1;
          end
        end
        PULSE: begin
          if (tick && pcnt[c] == 8'd1)
            st_nx[c] = WAITREL;
        end
        WAITREL: begin
          if (!stable[8+c]) st_nx[c] = IDLE;
        end
        default: st_nx[c] = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++)
      pulse[c] = (st[c] == PULSE);
  end

  assign coin_inp = ~pulse;
  assign counted  = take;
`else
  assign coin_inp = ~stable[9:8];
  assign counted  = rise;
`endif

  always_ff @(posedge MCLK) begin
    if (!RESET_N)
      coincnt <= '0;
    else
      coincnt <= coincnt
               + {7'd0, counted[0]}
               + {7'd0, counted[1]};
  end

  always_ff @(posedge MCLK) begin
    if (!RESET_N)
      inp <= 11'h7FF;
    else
      inp <= {~stable[10], coin_inp, ~stable[7:0]};
  end

  assign io.INP     = inp;
  assign io.COINCNT = coincnt;
endmodule

// File: tb/tb_atetris_inp_cond.sv
// Directed bench for atetris_inp_cond with a time-stamped scoreboard.
// Expectations follow ATETRIS_COIN_PULSE_EN when it is defined.
module tb_atetris_inp_cond;
  logic clk = 1'b0;
  logic rst_n;

  atetris_inp_cond_if io ();

  atetris_inp_cond #(
    .TICK_DIV(4),
    .DB_CNT  (3),
    .COIN_LEN(5)
  ) dut (
    .MCLK   (clk),
    .RESET_N(rst_n),
    .io     (io)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          at;
    bit          kind;
    logic [10:0] mask;
    logic [10:0] val;
    string       tag;
  } exp_t;

  exp_t sb [$];
  exp_t e;
  int   gcyc = 0;
  int   rel0 = 0;
  int   nvec = 0;
  int   nerr = 0;

  always @(posedge clk) gcyc <= gcyc + 1;

  function automatic void push(int at, bit kind,
      logic [10:0] mask, logic [10:0] val, string tag);
    exp_t x;
    int   i;
    x = '{at, kind, mask, val, tag};
    i = 0;
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, x);
  endfunction

  function automatic void pi(int at, logic [10:0] m,
      logic [10:0] v, string tag);
    push(at, 1'b0, m, v, tag);
  endfunction

  function automatic void pc(int at, int v, string tag);
    push(at, 1'b1, 11'h0FF, 11'(v), tag);
  endfunction

  // scoreboard: pop every expectation due on this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= gcyc) begin
      e = sb.pop_front();
      nvec++;
      if (e.kind) begin
        assert (io.COINCNT === e.val[7:0]) else begin
          nerr++;
          $error("FAIL %s: COINCNT observed %0d expected %0d",
                 e.tag, io.COINCNT, e.val[7:0]);
        end
      end else begin
        assert ((io.INP & e.mask) === (e.val & e.mask)) else begin
          nerr++;
          $error("FAIL %s: INP observed %h expected %h mask %h",
                 e.tag, io.INP, e.val, e.mask);
        end
      end
    end
  end

  task automatic step(int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic rst(int n);
    rst_n = 1'b0;
    step(n);
    rst_n = 1'b1;
    rel0  = gcyc;
  endtask

  // first tick edge at or after cycle g
  function automatic int nt(int g);
    int r;
    r = g - rel0;
    if (r < 4) r = 4;
    else       r = ((r + 3) / 4) * 4;
    return rel0 + r;
  endfunction

  // edge on which a level applied after edge a becomes stable
  function automatic int acc(int a);
    return nt(a + 3) + 8;
  endfunction

  task automatic press(logic [1:0] c);
    io.IRAW[9:8] = c;
    step(16);
    io.IRAW[9:8] = 2'b00;
    step(24);
  endtask

  initial begin
    int a;
    int t;
    int t2;
    int g;

    rst_n   = 1'b0;
    io.IRAW = 11'h7FF;
    for (int k = 1; k <= 3; k++) begin
      pi(k, 11'h7FF, 11'h7FF, "rst_inp");
      pc(k, 0, "rst_cnt");
    end
    step(3);
    rst_n   = 1'b1;
    io.IRAW = 11'h000;
    rel0    = gcyc;
    pi(rel0 + 14, 11'h7FF, 11'h7FF, "idle_inp");
    pc(rel0 + 14, 0, "idle_cnt");
    step(20);

    a = gcyc;
    io.IRAW[0] = 1'b1;
    t = acc(a);
    pi(t,      11'h001, 11'h001, "p1ro_pre");
    pi(t + 1,  11'h001, 11'h000, "p1ro_fall");
    pi(t + 10, 11'h001, 11'h000, "p1ro_hold");
    step(t + 12 - gcyc);
    a = gcyc;
    io.IRAW[0] = 1'b0;
    t = acc(a);
    pi(t,     11'h001, 11'h000, "p1ro_relpre");
    pi(t + 1, 11'h001, 11'h001, "p1ro_rel");
    step(t + 4 - gcyc);

    a = gcyc;
    io.IRAW[4] = 1'b1;
    for (int k = 1; k <= 10; k++)
      pi(a + 2 * k, 11'h7FF, 11'h7FF, "glitch");
    pc(a + 20, 0, "glitch_cnt");
    step(6);
    io.IRAW[4] = 1'b0;
    step(20);

    a = gcyc;
    io.IRAW[8] = 1'b1;
    t = acc(a);
    pc(t - 1, 0, "coin1_cnt0");
    pc(t,     1, "coin1_cnt1");
    pi(t,     11'h100, 11'h100, "coin1_pre");
    pi(t + 1, 11'h100, 11'h000, "coin1_on");
`ifdef ATETRIS_COIN_PULSE_EN
    pi(t + 20, 11'h100, 11'h000, "coin1_last");
    pi(t + 21, 11'h100, 11'h100, "coin1_end");
    pi(t + 60, 11'h100, 11'h100, "coin1_once");
`else
    pi(t + 20, 11'h100, 11'h000, "coin1_lvl20");
    pi(t + 21, 11'h100, 11'h000, "coin1_lvl21");
    pi(t + 60, 11'h100, 11'h000, "coin1_lvl60");
`endif
    pc(t + 60, 1, "coin1_cnt_hold");
    step(100);
    a = gcyc;
    io.IRAW[8] = 1'b0;
    t2 = acc(a);
`ifndef ATETRIS_COIN_PULSE_EN
    pi(t2, 11'h100, 11'h000, "coin1_relpre");
`endif
    pi(t2 + 1, 11'h7FF, 11'h7FF, "coin1_rel");
    pc(t2 + 1, 1, "coin1_cnt_rel");
    step(t2 + 4 - gcyc);

    g = gcyc;
    rst(2);
    pc(g + 1, 0, "rst2_cnt");
    a = gcyc;
    io.IRAW[9:8] = 2'b11;
    t = acc(a);
    pc(t - 1, 0, "dual_cnt0");
    pc(t,     2, "dual_cnt2");
    pi(t,      11'h300, 11'h300, "dual_pre");
    pi(t + 1,  11'h300, 11'h000, "dual_on");
    pi(t + 20, 11'h300, 11'h000, "dual_last");
`ifdef ATETRIS_COIN_PULSE_EN
    pi(t + 21, 11'h300, 11'h300, "dual_end");
`else
    pi(t + 21, 11'h300, 11'h000, "dual_lvl");
`endif
    step(40);
    io.IRAW[9:8] = 2'b00;
    step(40);
    for (int k = 0; k < 126; k++) press(2'b11);
    pc(gcyc + 1, 254, "cnt_254");
    press(2'b01);
    pc(gcyc + 1, 255, "cnt_255");
    step(2);
    a = gcyc;
    io.IRAW[9:8] = 2'b11;
    t = acc(a);
    pc(t - 1, 255, "wrap_pre");
    pc(t,     1,   "wrap_post");
    step(16);
    io.IRAW[9:8] = 2'b00;
    step(30);

    a = gcyc;
    io.IRAW[8] = 1'b1;
    t = acc(a);
    step(t + 5 - gcyc);
    pi(gcyc, 11'h100, 11'h000, "mid_on");
    pc(gcyc, 2, "mid_cnt");
    g = gcyc;
    pi(g + 1, 11'h7FF, 11'h7FF, "abort_inp");
    pc(g + 1, 0, "abort_cnt");
    rst(2);
    t = acc(rel0);
    pc(t - 1, 0, "held_cnt0");
    pc(t,     1, "held_cnt1");
    pi(t,     11'h100, 11'h100, "held_pre");
    pi(t + 1, 11'h100, 11'h000, "held_on");
    step(t + 25 - gcyc);
    io.IRAW[8] = 1'b0;
    step(40);

    for (int k = 0; k < 50 && sb.size() > 0; k++) step(1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      nvec++;
      nerr++;
      $display("FAIL %s: never checked, due cycle %0d",
               e.tag, e.at);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
